// File: rtl/bin_bcd_converter_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// blank digit code, FSM state encoding and the internal digit-count helper.
package bin_bcd_converter_pkg;

    // Digit code that the downstream 7-segment decoder shows as all segments off
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of decimal digits needed to hold any bin_w-bit value:
    // ceil(bin_w * log10(2)), with log10(2) approximated as 0.30103
    function automatic int calc_idig(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Add-3 correction, purely combinational
    always_comb begin
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with display-range saturation.
// One value per in_valid/in_ready handshake; result appears BIN_W+1 cycles after
// the accepting edge as a one-cycle out_valid pulse, bcd/overflow held afterwards.
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits (except digit 0)
// are replaced by the blank code when the value is in range.
module bin_bcd_converter
    import bin_bcd_converter_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int IDIG = calc_idig(BIN_W);
    localparam int SW   = 4 * IDIG + BIN_W;
    localparam int CW   = $clog2(BIN_W + 1);

    state_t                r_state;
    logic [SW-1:0]         r_scratch;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_overflow;

    logic [SW-1:0]         w_adj;
    logic [SW-1:0]         w_shifted;
    logic [4*DIGITS-1:0]   w_bcd_next;
    logic                  w_ovf_next;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  w_lead;
`endif

    // The binary part of the scratch register passes through unchanged;
    // each internal digit gets its add-3 correction before the shift.
    assign w_adj[BIN_W-1:0] = r_scratch[BIN_W-1:0];

    for (genvar g = 0; g < IDIG; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .i_digit (r_scratch[BIN_W + 4*g +: 4]),
            .o_digit (w_adj[BIN_W + 4*g +: 4])
        );
    end

    assign w_shifted = w_adj << 1;

    // Final result from the converted digits: saturation and optional blanking
    always_comb begin
        w_ovf_next = 1'b0;
        w_bcd_next = {DIGITS{4'h9}};
`ifdef LEADING_ZERO_BLANK_EN
        w_lead     = 1'b1;
`endif
        for (int i = DIGITS; i < IDIG; i++) begin
            w_ovf_next = w_ovf_next | (r_scratch[BIN_W + 4*i +: 4] != 4'd0);
        end
        if (w_ovf_next) begin
            w_bcd_next = {DIGITS{4'h9}};
        end else begin
            w_bcd_next = r_scratch[BIN_W +: 4*DIGITS];
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (w_lead && (w_bcd_next[4*i +: 4] == 4'd0)) begin
                    w_bcd_next[4*i +: 4] = BCD_BLANK;
                end else begin
                    w_lead = 1'b0;
                end
            end
`endif
        end
    end

    // Conversion FSM: capture on accept, BIN_W add-3/shift steps, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_scratch   <= {SW{1'b0}};
            r_bit_cnt   <= {CW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bcd       <= {(4*DIGITS){1'b0}};
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // bin is sampled only on this accepting edge
                        r_scratch  <= {{(4*IDIG){1'b0}}, bin};
                        r_bit_cnt  <= CW'(BIN_W);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // First step: digits are all zero, so this is the first shift
                    r_scratch <= w_shifted;
                    r_bit_cnt <= r_bit_cnt - CW'(1);
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_scratch <= w_shifted;
                    r_bit_cnt <= r_bit_cnt - CW'(1);
                    if (r_bit_cnt == CW'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd       <= w_bcd_next;
                    r_overflow  <= w_ovf_next;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_bin_bcd_converter.sv
// Directed self-checking bench for bin_bcd_converter (BIN_W=16, DIGITS=4).
// Expected values follow LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_bin_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic [15:0] bcd;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    bin_bcd_converter #(.BIN_W(16), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .bcd       (bcd),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: decimal digits by division, saturate above 9999, optional blanking
    function automatic logic [16:0] model(input int v);
        logic [15:0] b;
        logic [3:0]  d;
        logic        lead;
        int          t;
        if (v > 9999) return {1'b1, 16'h9999};
        t = v;
        for (int i = 0; i < 4; i++) begin
            d = 4'(t % 10);
            b[4*i +: 4] = d;
            t = t / 10;
        end
        lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (lead && (b[4*i +: 4] == 4'h0)) b[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake-and-result transaction with latency and hold checks
    task automatic run_conv(input logic [15:0] v, input logic [16:0] exp, input string tag);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bin      = v;
        tick();
        in_valid = 1'b0;
        bin      = ~v;
        check_eq({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 40);
        check_eq({tag, "_lat"}, lat, 32'd17);
        check_eq({tag, "_res"}, {15'd0, overflow, bcd}, {15'd0, exp});
        tick();
        check_eq({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_hold"}, {15'd0, overflow, bcd}, {15'd0, exp});
    endtask

    logic [15:0] dir_val [8];
    logic [16:0] dir_exp [8];

    initial begin
        int acc_n;
        int pulse_n;
        int cyc;
        logic acc;
        logic [15:0] v;

        dir_val[0] = 16'd1234;  dir_exp[0] = {1'b0, 16'h1234};
        dir_val[1] = 16'd9999;  dir_exp[1] = {1'b0, 16'h9999};
        dir_val[2] = 16'd10000; dir_exp[2] = {1'b1, 16'h9999};
        dir_val[3] = 16'd65535; dir_exp[3] = {1'b1, 16'h9999};
        dir_val[4] = 16'd8421;  dir_exp[4] = {1'b0, 16'h8421};
`ifdef LEADING_ZERO_BLANK_EN
        dir_val[5] = 16'd0;     dir_exp[5] = {1'b0, 16'hFFF0};
        dir_val[6] = 16'd42;    dir_exp[6] = {1'b0, 16'hFF42};
        dir_val[7] = 16'd1005;  dir_exp[7] = {1'b0, 16'h1005};
`else
        dir_val[5] = 16'd0;     dir_exp[5] = {1'b0, 16'h0000};
        dir_val[6] = 16'd42;    dir_exp[6] = {1'b0, 16'h0042};
        dir_val[7] = 16'd1005;  dir_exp[7] = {1'b0, 16'h1005};
`endif

        rst_n    = 1'b0;
        in_valid = 1'b0;
        bin      = 16'd0;
        repeat (3) tick();
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_res", {15'd0, overflow, bcd}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_conv(dir_val[i], dir_exp[i], $sformatf("dir%0d", i));
        end

        // Back-to-back with in_valid held high; bin scrambled whenever not acceptable
        acc_n   = 0;
        pulse_n = 0;
        cyc     = 0;
        in_valid = 1'b1;
        bin      = 16'd1;
        while (cyc < 80) begin
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (out_valid) begin
                check_eq($sformatf("b2b_res%0d", pulse_n), {15'd0, overflow, bcd},
                         {15'd0, model(pulse_n + 1)});
                pulse_n++;
            end
            if (acc) acc_n++;
            if (acc_n >= 3) in_valid = 1'b0;
            if (in_ready) bin = 16'(acc_n + 1);
            else          bin = 16'($urandom_range(0, 65535));
        end
        check_eq("b2b_pulses", pulse_n, 32'd3);

        // Reset in the middle of a conversion aborts it without a result
        run_conv(16'd777, model(777), "pre_rst");
        in_valid = 1'b1;
        bin      = 16'd4321;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("arst_res", {15'd0, overflow, bcd}, 32'd0);
        #2;
        rst_n = 1'b1;
        pulse_n = 0;
        repeat (25) begin
            tick();
            if (out_valid) pulse_n++;
        end
        check_eq("arst_nopulse", pulse_n, 32'd0);
        run_conv(16'd500, model(500), "post_rst");

        // Sampled sweep against the division-based reference
        for (int i = 0; i < 120; i++) begin
            v = 16'($urandom_range(0, 65535));
            if (i < 40) v = 16'($urandom_range(0, 9999));
            run_conv(v, model(int'(v)), $sformatf("sweep_%0d", v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
